// File: rtl/reg_xfer_seq.sv
// rtl/reg_xfer_seq.sv - register transfer sequencer (MOV / ALU) driving shared-bus asserts and register loads
// Optional build macro: REG_XFER_SEQ_STRETCH_EN (two-cycle SETUP for slower bus settling).
module reg_xfer_seq #(
   parameter int DELAY_RISE = 0,
   parameter int DELAY_FALL = 0
) (
   input  logic       CLK,
   input  logic       RST_bar,
   input  logic       REQ,
   input  logic [1:0] OP,
   input  logic [1:0] SRC,
   input  logic [1:0] SRC_B,
   input  logic [1:0] DST,
   output logic [3:0] ASSERT_MAIN_bar,
   output logic [3:0] ASSERT_LHS_bar,
   output logic [3:0] ASSERT_RHS_bar,
   output logic [3:0] LOAD,
   output logic       ALU_ASSERT_MAIN_bar,
   output logic       BUSY,
   output logic       ACK,
   output logic       ERR
);

   // Rise/fall delays annotate the timing model only; the logic ignores them.
   if (DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_negative_delay
   end

`ifdef REG_XFER_SEQ_STRETCH_EN
   localparam logic SETUP_EXTRA = 1'b1;
`else
   localparam logic SETUP_EXTRA = 1'b0;
`endif

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_LOAD, S_HOLD} state_t;

   typedef struct packed {
      logic [3:0] main_n;
      logic [3:0] lhs_n;
      logic [3:0] rhs_n;
      logic       alu_n;
   } en_t;

   localparam en_t EN_IDLE = '{main_n: 4'hF, lhs_n: 4'hF, rhs_n: 4'hF, alu_n: 1'b1};

   function automatic en_t f_enables(input logic is_alu, input logic [1:0] src,
                                     input logic [1:0] src_b, input logic [1:0] dst);
      en_t e;
      e = EN_IDLE;
      if (is_alu) begin
         e.lhs_n = ~(4'b0001 << src);
         e.rhs_n = ~(4'b0001 << src_b);
         e.alu_n = 1'b0;
      end else if (src != dst) begin
         e.main_n = ~(4'b0001 << src);
      end
      return e;
   endfunction

   // A MOV onto itself keeps its timing slot but touches nothing.
   function automatic logic [3:0] f_load(input logic is_alu, input logic [1:0] src,
                                         input logic [1:0] dst);
      if (!is_alu && src == dst) return 4'h0;
      return 4'b0001 << dst;
   endfunction

   state_t     r_state;
   logic       r_is_alu;
   logic [1:0] r_src;
   logic [1:0] r_src_b;
   logic [1:0] r_dst;
   logic       r_setup_extra;
   en_t        r_en;
   logic [3:0] r_load;
   logic       r_busy;
   logic       r_ack;
   logic       r_err;

   logic w_is_alu;
   logic w_op_valid;
   logic w_hazard;
   logic w_accept;
   logic w_reject;

   assign w_is_alu   = (OP == 2'b01);
   assign w_op_valid = (OP[1] == 1'b0);
   // ALU writing one of its own operands would loop through the transparent latch.
   assign w_hazard   = w_is_alu && (DST == SRC || DST == SRC_B);
   assign w_accept   = REQ && w_op_valid && !w_hazard;
   assign w_reject   = REQ && (!w_op_valid || w_hazard);

   always_ff @(posedge CLK) begin
      if (!RST_bar) begin
         r_state       <= S_IDLE;
         r_is_alu      <= 1'b0;
         r_src         <= 2'd0;
         r_src_b       <= 2'd0;
         r_dst         <= 2'd0;
         r_setup_extra <= 1'b0;
         r_en          <= EN_IDLE;
         r_load        <= 4'h0;
         r_busy        <= 1'b0;
         r_ack         <= 1'b0;
         r_err         <= 1'b0;
      end else begin
         r_ack  <= 1'b0;
         r_err  <= 1'b0;
         r_load <= 4'h0;
         case (r_state)
            S_IDLE: begin
               r_en   <= EN_IDLE;
               r_busy <= 1'b0;
               if (w_accept) begin
                  r_state       <= S_SETUP;
                  r_is_alu      <= w_is_alu;
                  r_src         <= SRC;
                  r_src_b       <= SRC_B;
                  r_dst         <= DST;
                  r_setup_extra <= SETUP_EXTRA;
                  r_busy        <= 1'b1;
                  r_en          <= f_enables(w_is_alu, SRC, SRC_B, DST);
               end else if (w_reject) begin
                  r_err <= 1'b1;
               end
            end
            S_SETUP: begin
               r_en <= f_enables(r_is_alu, r_src, r_src_b, r_dst);
               if (r_setup_extra) begin
                  r_setup_extra <= 1'b0;
               end else begin
                  r_state <= S_LOAD;
                  r_load  <= f_load(r_is_alu, r_src, r_dst);
               end
            end
            S_LOAD: begin
               r_en    <= f_enables(r_is_alu, r_src, r_src_b, r_dst);
               r_state <= S_HOLD;
               r_ack   <= 1'b1;
            end
            S_HOLD: begin
               r_en    <= EN_IDLE;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign ASSERT_MAIN_bar     = r_en.main_n;
   assign ASSERT_LHS_bar      = r_en.lhs_n;
   assign ASSERT_RHS_bar      = r_en.rhs_n;
   assign ALU_ASSERT_MAIN_bar = r_en.alu_n;
   assign LOAD                = r_load;
   assign BUSY                = r_busy;
   assign ACK                 = r_ack;
   assign ERR                 = r_err;

endmodule

// File: tb/tb_reg_xfer_seq.sv
// tb/tb_reg_xfer_seq.sv - scoreboard bench for reg_xfer_seq
// Honors REG_XFER_SEQ_STRETCH_EN to match the DUT build.
module tb_reg_xfer_seq;

`ifdef REG_XFER_SEQ_STRETCH_EN
   localparam int NS = 2;
`else
   localparam int NS = 1;
`endif

   localparam int PH_IDLE  = 0;
   localparam int PH_SETUP = 1;
   localparam int PH_LOAD  = 2;
   localparam int PH_HOLD  = 3;
   localparam int PH_ERR   = 4;

   typedef struct packed {
      logic [3:0] main_n;
      logic [3:0] lhs_n;
      logic [3:0] rhs_n;
      logic [3:0] load;
      logic       alu_n;
      logic       busy;
      logic       ack;
      logic       err;
   } ovec_t;

   logic       CLK;
   logic       RST_bar;
   logic       REQ;
   logic [1:0] OP;
   logic [1:0] SRC;
   logic [1:0] SRC_B;
   logic [1:0] DST;
   logic [3:0] ASSERT_MAIN_bar;
   logic [3:0] ASSERT_LHS_bar;
   logic [3:0] ASSERT_RHS_bar;
   logic [3:0] LOAD;
   logic       ALU_ASSERT_MAIN_bar;
   logic       BUSY;
   logic       ACK;
   logic       ERR;

   int n_checks = 0;
   int n_errors = 0;
   ovec_t sb[$];

   reg_xfer_seq dut (
      .CLK                 (CLK),
      .RST_bar             (RST_bar),
      .REQ                 (REQ),
      .OP                  (OP),
      .SRC                 (SRC),
      .SRC_B               (SRC_B),
      .DST                 (DST),
      .ASSERT_MAIN_bar     (ASSERT_MAIN_bar),
      .ASSERT_LHS_bar      (ASSERT_LHS_bar),
      .ASSERT_RHS_bar      (ASSERT_RHS_bar),
      .LOAD                (LOAD),
      .ALU_ASSERT_MAIN_bar (ALU_ASSERT_MAIN_bar),
      .BUSY                (BUSY),
      .ACK                 (ACK),
      .ERR                 (ERR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
      end
   endtask

   function automatic logic legal(input logic [1:0] op, input logic [1:0] src,
                                  input logic [1:0] srcb, input logic [1:0] dst);
      if (op[1]) return 1'b0;
      if (op == 2'b01 && (dst == src || dst == srcb)) return 1'b0;
      return 1'b1;
   endfunction

   function automatic ovec_t exp_vec(input int ph, input logic [1:0] op, input logic [1:0] src,
                                     input logic [1:0] srcb, input logic [1:0] dst);
      ovec_t v;
      v = '{main_n: 4'hF, lhs_n: 4'hF, rhs_n: 4'hF, load: 4'h0,
            alu_n: 1'b1, busy: 1'b0, ack: 1'b0, err: 1'b0};
      if (ph == PH_ERR) v.err = 1'b1;
      if (ph == PH_SETUP || ph == PH_LOAD || ph == PH_HOLD) begin
         v.busy = 1'b1;
         if (op == 2'b01) begin
            v.lhs_n[src]  = 1'b0;
            v.rhs_n[srcb] = 1'b0;
            v.alu_n       = 1'b0;
            if (ph == PH_LOAD) v.load[dst] = 1'b1;
         end else if (src != dst) begin
            v.main_n[src] = 1'b0;
            if (ph == PH_LOAD) v.load[dst] = 1'b1;
         end
         if (ph == PH_HOLD) v.ack = 1'b1;
      end
      return v;
   endfunction

   function automatic ovec_t idle_vec();
      return exp_vec(PH_IDLE, 2'b00, 2'd0, 2'd0, 2'd0);
   endfunction

   always @(negedge CLK) begin
      ovec_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("main_n", 32'(ASSERT_MAIN_bar), 32'(e.main_n));
         chk("lhs_n",  32'(ASSERT_LHS_bar),  32'(e.lhs_n));
         chk("rhs_n",  32'(ASSERT_RHS_bar),  32'(e.rhs_n));
         chk("load",   32'(LOAD),            32'(e.load));
         chk("alu_n",  32'(ALU_ASSERT_MAIN_bar), 32'(e.alu_n));
         chk("busy",   32'(BUSY),            32'(e.busy));
         chk("ack",    32'(ACK),             32'(e.ack));
         chk("err",    32'(ERR),             32'(e.err));
      end
   end

   task automatic push_xfer(input logic [1:0] op, input logic [1:0] src,
                            input logic [1:0] srcb, input logic [1:0] dst);
      for (int i = 0; i < NS; i++) sb.push_back(exp_vec(PH_SETUP, op, src, srcb, dst));
      sb.push_back(exp_vec(PH_LOAD, op, src, srcb, dst));
      sb.push_back(exp_vec(PH_HOLD, op, src, srcb, dst));
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (sb.size() > 0 && t < 100) begin
         @(negedge CLK);
         t++;
      end
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   task automatic scramble_inputs();
      OP    = 2'($urandom_range(0, 3));
      SRC   = 2'($urandom_range(0, 3));
      SRC_B = 2'($urandom_range(0, 3));
      DST   = 2'($urandom_range(0, 3));
   endtask

   task automatic do_req(input logic [1:0] op, input logic [1:0] src,
                         input logic [1:0] srcb, input logic [1:0] dst);
      @(posedge CLK); #1;
      REQ = 1'b1; OP = op; SRC = src; SRC_B = srcb; DST = dst;
      sb.push_back(idle_vec());
      if (legal(op, src, srcb, dst)) push_xfer(op, src, srcb, dst);
      else sb.push_back(exp_vec(PH_ERR, op, src, srcb, dst));
      sb.push_back(idle_vec());
      @(posedge CLK); #1;
      REQ = 1'b0;
      scramble_inputs();
      wait_drain();
   endtask

   initial begin
      RST_bar = 1'b0; REQ = 1'b0; OP = 2'd0; SRC = 2'd0; SRC_B = 2'd0; DST = 2'd0;
      repeat (2) @(posedge CLK);
      #1;
      sb.push_back(idle_vec());
      wait_drain();
      RST_bar = 1'b1;

      do_req(2'b00, 2'd1, 2'd0, 2'd2);
      do_req(2'b01, 2'd0, 2'd3, 2'd2);
      do_req(2'b01, 2'd2, 2'd1, 2'd2);
      do_req(2'b01, 2'd0, 2'd1, 2'd1);
      do_req(2'b11, 2'd0, 2'd1, 2'd2);
      do_req(2'b10, 2'd3, 2'd1, 2'd0);
      do_req(2'b00, 2'd3, 2'd0, 2'd3);
      do_req(2'b01, 2'd1, 2'd1, 2'd0);
      do_req(2'b00, 2'd1, 2'd0, 2'd0);

      // REQ held high with new fields: the second transfer waits for HOLD to end.
      @(posedge CLK); #1;
      REQ = 1'b1; OP = 2'b00; SRC = 2'd0; SRC_B = 2'd2; DST = 2'd3;
      sb.push_back(idle_vec());
      push_xfer(2'b00, 2'd0, 2'd2, 2'd3);
      sb.push_back(idle_vec());
      push_xfer(2'b00, 2'd2, 2'd0, 2'd1);
      sb.push_back(idle_vec());
      @(posedge CLK); #1;
      OP = 2'b00; SRC = 2'd2; SRC_B = 2'd0; DST = 2'd1;
      repeat (NS + 3) @(posedge CLK);
      #1;
      REQ = 1'b0;
      wait_drain();

      // Reset during LOAD aborts with no ACK; REQ during reset is ignored.
      @(posedge CLK); #1;
      REQ = 1'b1; OP = 2'b00; SRC = 2'd1; SRC_B = 2'd0; DST = 2'd2;
      sb.push_back(idle_vec());
      for (int i = 0; i < NS; i++) sb.push_back(exp_vec(PH_SETUP, 2'b00, 2'd1, 2'd0, 2'd2));
      sb.push_back(exp_vec(PH_LOAD, 2'b00, 2'd1, 2'd0, 2'd2));
      @(posedge CLK); #1;
      REQ = 1'b0;
      repeat (NS) @(posedge CLK);
      #1;
      RST_bar = 1'b0; REQ = 1'b1; OP = 2'b00; SRC = 2'd0; DST = 2'd3;
      sb.push_back(idle_vec());
      @(posedge CLK); #1;
      RST_bar = 1'b1; REQ = 1'b0;
      sb.push_back(idle_vec());
      sb.push_back(idle_vec());
      wait_drain();

      for (int k = 0; k < 20; k++) begin
         do_req(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
